// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready input handshake,
// iterative shift-add multiply and an architectural NZVC flag register.
module seq_alu #(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               sf_q, sf_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         nzvc_q, nzvc_d;
    logic [3:0]         flags_q, flags_d;
    logic               ov_q, ov_d;

    logic [WIDTH-1:0]   b_op;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   op_res;
    logic               op_v;
    logic               op_c;
    logic [WIDTH-1:0]   mul_next;

    logic               ld;
    logic [WIDTH-1:0]   ld_res;
    logic               ld_v;
    logic               ld_c;
    logic               ld_sf;
    logic [3:0]         ld_nzvc;

    // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
    always_comb begin
        b_op   = (cntrl == OP_SUB) ? ~B : B;
        sum    = {1'b0, A} + {1'b0, b_op}
               + {{WIDTH{1'b0}}, (cntrl == OP_SUB)};
        op_res = '0;
        op_v   = 1'b0;
        op_c   = 1'b0;
        case (cntrl)
            OP_PASS: op_res = B;
            OP_ADD, OP_SUB: begin
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (A[WIDTH-1] ^ b_op[WIDTH-1] ^ sum[WIDTH-1])
                       ^ sum[WIDTH];
            end
            OP_AND:  op_res = A & B;
            OP_OR:   op_res = A | B;
            OP_XOR:  op_res = A ^ B;
            default: op_res = '0;
        endcase
    end

    always_comb begin
        mul_next = acc_q;
        if (b_q[cnt_q[CNT_W-2:0]]) begin
            mul_next = acc_q + (a_q << cnt_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sf_d    = sf_q;
        ld      = 1'b0;
        ld_res  = '0;
        ld_v    = 1'b0;
        ld_c    = 1'b0;
        ld_sf   = 1'b0;
        in_ready = (state_q == IDLE);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (cntrl == OP_MUL) begin
                        state_d = MUL;
                        a_d     = A;
                        b_d     = B;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sf_d    = set_flags;
                    end else begin
                        ld     = 1'b1;
                        ld_res = op_res;
                        ld_v   = op_v;
                        ld_c   = op_c;
                        ld_sf  = set_flags;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ld      = 1'b1;
                    ld_res  = mul_next;
                    ld_sf   = sf_q;
                end
            end
            default: state_d = IDLE;
        endcase

        ld_nzvc = {ld_res[WIDTH-1], (ld_res == '0), ld_v, ld_c};
        res_d   = ld ? ld_res : res_q;
        nzvc_d  = ld ? ld_nzvc : nzvc_q;
        flags_d = (ld && ld_sf) ? ld_nzvc : flags_q;
        ov_d    = ld;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sf_q    <= 1'b0;
            res_q   <= '0;
            nzvc_q  <= '0;
            flags_q <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sf_q    <= sf_d;
            res_q   <= res_d;
            nzvc_q  <= nzvc_d;
            flags_q <= flags_d;
            ov_q    <= ov_d;
        end
    end

    assign out_valid = ov_q;
    assign result    = res_q;
    assign negative  = nzvc_q[3];
    assign zero      = nzvc_q[2];
    assign overflow  = nzvc_q[1];
    assign carry_out = nzvc_q[0];
    assign flag_n    = flags_q[3];
    assign flag_z    = flags_q[2];
    assign flag_v    = flags_q[1];
    assign flag_c    = flags_q[0];

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: 64-bit instance for single-cycle ops,
// 8-bit instance for the iterative multiply and mid-multiply reset.
module tb_seq_alu;

    logic clk;
    logic reset;

    logic        iv64, ir64, sf64, ov64;
    logic [63:0] a64, b64, r64;
    logic [2:0]  op64;
    logic        n64, z64, v64, c64, fn64, fz64, fv64, fc64;

    logic        iv8, ir8, sf8, ov8;
    logic [7:0]  a8, b8, r8;
    logic [2:0]  op8;
    logic        n8, z8, v8, c8, fn8, fz8, fv8, fc8;

    int n_chk;
    int n_fail;
    int busy;
    int ovs;

    seq_alu #(.WIDTH(64)) u64 (
        .clk(clk), .reset(reset),
        .in_valid(iv64), .in_ready(ir64),
        .A(a64), .B(b64), .cntrl(op64), .set_flags(sf64),
        .out_valid(ov64), .result(r64),
        .negative(n64), .zero(z64), .overflow(v64), .carry_out(c64),
        .flag_n(fn64), .flag_z(fz64), .flag_v(fv64), .flag_c(fc64)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset),
        .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .cntrl(op8), .set_flags(sf8),
        .out_valid(ov8), .result(r8),
        .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8),
        .flag_n(fn8), .flag_z(fz8), .flag_v(fv8), .flag_c(fc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive64(input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic sf);
        iv64 = 1'b1;
        op64 = op;
        a64  = a;
        b64  = b;
        sf64 = sf;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        iv64 = 0; a64 = 0; b64 = 0; op64 = 0; sf64 = 0;
        iv8  = 0; a8  = 0; b8  = 0; op8  = 0; sf8  = 0;

        for (int i = 0; i < 4; i++) begin
            iv64 = 1'($urandom_range(0, 1));
            iv8  = 1'($urandom_range(0, 1));
            op64 = 3'($urandom_range(0, 7));
            op8  = 3'b001;
            tick();
        end
        chk("rst_ready64", 64'(ir64), 64'd1);
        chk("rst_ov64", 64'(ov64), 64'd0);
        chk("rst_res64", r64, 64'd0);
        chk("rst_nzvc64", 64'({n64, z64, v64, c64}), 64'd0);
        chk("rst_flags64", 64'({fn64, fz64, fv64, fc64}), 64'd0);
        chk("rst_ready8", 64'(ir8), 64'd1);
        chk("rst_ov8", 64'(ov8), 64'd0);
        iv64 = 0;
        iv8  = 0;
        reset = 1'b0;
        tick();

        drive64(3'b010, 64'd1, 64'd1, 1'b0);
        tick();
        iv64 = 0;
        chk("add1_ov", 64'(ov64), 64'd1);
        chk("add1_res", r64, 64'd2);
        chk("add1_nzvc", 64'({n64, z64, v64, c64}), 64'd0);
        tick();
        chk("add1_ov_drop", 64'(ov64), 64'd0);
        chk("add1_hold", r64, 64'd2);

        drive64(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'hF, 1'b1);
        tick();
        iv64 = 0;
        chk("addv_res", r64, 64'h8000_0000_0000_000E);
        chk("addv_nzvc", 64'({n64, z64, v64, c64}), 64'b1010);
        chk("addv_flags", 64'({fn64, fz64, fv64, fc64}), 64'b1010);

        drive64(3'b011, 64'h7F5F_FBFF_0FFF_FFFF,
                64'h7F5F_FBFF_0FFF_FFFF, 1'b1);
        tick();
        chk("sub_res", r64, 64'd0);
        chk("sub_nzvc", 64'({n64, z64, v64, c64}), 64'b0101);
        chk("sub_flags", 64'({fn64, fz64, fv64, fc64}), 64'b0101);
        drive64(3'b100, 64'h7F5F_FBFF_0FFF_FFFF,
                64'h7F5F_FBFF_0FFF_FFFF, 1'b0);
        tick();
        iv64 = 0;
        chk("and_res", r64, 64'h7F5F_FBFF_0FFF_FFFF);
        chk("and_nzvc", 64'({n64, z64, v64, c64}), 64'b0000);
        chk("and_flags_hold", 64'({fn64, fz64, fv64, fc64}), 64'b0101);

        drive64(3'b110, 64'hF0F0, 64'h0FF0, 1'b0);
        tick();
        chk("xor_ov", 64'(ov64), 64'd1);
        chk("xor_res", r64, 64'hFF00);
        drive64(3'b101, 64'hF0F0, 64'h0FF0, 1'b0);
        tick();
        chk("or_ov", 64'(ov64), 64'd1);
        chk("or_res", r64, 64'hFFF0);
        drive64(3'b000, 64'hF0F0, 64'h0FF0, 1'b0);
        tick();
        iv64 = 0;
        chk("pass_ov", 64'(ov64), 64'd1);
        chk("pass_res", r64, 64'h0FF0);

        drive64(3'b111, 64'h1234, 64'h5678, 1'b0);
        tick();
        iv64 = 0;
        chk("rsvd_res", r64, 64'd0);
        chk("rsvd_nzvc", 64'({n64, z64, v64, c64}), 64'b0100);

        iv8 = 1'b1; op8 = 3'b001; a8 = 8'd13; b8 = 8'd11; sf8 = 1'b1;
        tick();
        busy = 0;
        ovs  = 0;
        while (!ir8 && busy < 20) begin
            busy++;
            if (ov8) ovs++;
            iv8 = busy[0];
            op8 = 3'b010;
            a8  = 8'd1;
            b8  = 8'd1;
            sf8 = 1'b0;
            tick();
        end
        iv8 = 0;
        chk("mul_busy", 64'(busy), 64'd8);
        chk("mul_no_early_ov", 64'(ovs), 64'd0);
        chk("mul_ov", 64'(ov8), 64'd1);
        chk("mul_res", 64'(r8), 64'h8F);
        chk("mul_nzvc", 64'({n8, z8, v8, c8}), 64'b1000);
        chk("mul_flags", 64'({fn8, fz8, fv8, fc8}), 64'b1000);
        tick();
        chk("mul_ov_drop", 64'(ov8), 64'd0);
        chk("mul_hold", 64'(r8), 64'h8F);

        iv8 = 1'b1; op8 = 3'b001; a8 = 8'd7; b8 = 8'd9; sf8 = 1'b1;
        tick();
        iv8 = 0;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("abort_ready", 64'(ir8), 64'd1);
        chk("abort_ov", 64'(ov8), 64'd0);
        chk("abort_res", 64'(r8), 64'd0);
        chk("abort_flags", 64'({fn8, fz8, fv8, fc8}), 64'd0);
        tick();
        reset = 1'b0;
        ovs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov8) ovs++;
        end
        chk("abort_no_ov", 64'(ovs), 64'd0);
        iv8 = 1'b1; op8 = 3'b010; a8 = 8'd5; b8 = 8'd3; sf8 = 1'b0;
        tick();
        iv8 = 0;
        chk("post_add_ov", 64'(ov8), 64'd1);
        chk("post_add_res", 64'(r8), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
